quad_encoder_array: RTL and testbench

- Parametrised multi-channel successor to the single-channel quadrature counter on the motor board.
- Per channel: pin synchronisation, glitch filtering, x4 decode, signed position, windowed velocity and a sticky illegal-transition flag.
- Feeds position and velocity to the coms and motorControl paths. Runs on the 32 MHz PLL clock.

---
 rtl/quad_encoder_array.sv | 203 ++++++++++++++++++++
 tb/tb_quad_encoder_array.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature decoder: pin sync, glitch filter, x4 decode, position, windowed velocity, error flag.
// Define QUAD_ENC_INDEX_EN to add the quadI index input and the sticky index_seen output.
module quad_encoder_array #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned COUNT_WIDTH   = 24,
    parameter int unsigned FILTER_CYCLES = 100,
    parameter int unsigned VEL_WINDOW    = 32000,
    parameter int unsigned VEL_WIDTH     = 16
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             quadA,
    input  logic [CHANNELS-1:0]             quadB,
`ifdef QUAD_ENC_INDEX_EN
    input  logic [CHANNELS-1:0]             quadI,
    output logic [CHANNELS-1:0]             index_seen,
`endif
    input  logic [CHANNELS-1:0]             zero,
    input  logic [CHANNELS-1:0]             error_clear,
    output logic [CHANNELS*COUNT_WIDTH-1:0] count,
    output logic [CHANNELS*VEL_WIDTH-1:0]   velocity,
    output logic                            vel_valid,
    output logic [CHANNELS-1:0]             error
);

`ifdef QUAD_ENC_INDEX_EN
    localparam int unsigned PINS = 3;
`else
    localparam int unsigned PINS = 2;
`endif
    localparam int unsigned NPIN = CHANNELS * PINS;
    localparam int unsigned FCW  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned SW   = $clog2(FILTER_CYCLES + 4);
    localparam int unsigned WW   = $clog2(VEL_WINDOW);
    localparam int unsigned VW1  = VEL_WIDTH + 1;
    localparam logic [VEL_WIDTH-1:0] VMAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
    localparam logic [VEL_WIDTH-1:0] VMIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

    logic [NPIN-1:0] raw;
    logic [NPIN-1:0] sync1_q;
    logic [NPIN-1:0] sync2_q;
    logic [NPIN-1:0] filt;
    logic [SW-1:0]   settle_q;
    logic [WW-1:0]   win_q;
    logic            win_term;
    logic            settling;
    logic            vel_valid_q;

    // Per-channel pin order inside raw/filt: A, B, then I when present.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_pins
        assign raw[ch*PINS]     = quadA[ch];
        assign raw[ch*PINS + 1] = quadB[ch];
`ifdef QUAD_ENC_INDEX_EN
        assign raw[ch*PINS + 2] = quadI[ch];
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    if (FILTER_CYCLES == 0) begin : g_nofilt
        assign filt = sync2_q;
    end else begin : g_filt
        logic [FCW-1:0]  stab_q [NPIN];
        logic [NPIN-1:0] filt_q;

        // A pin change is accepted only after FILTER_CYCLES consecutive differing samples.
        always_ff @(posedge CLK) begin
            if (reset) begin
                filt_q <= '0;
                for (int p = 0; p < int'(NPIN); p++) stab_q[p] <= '0;
            end else begin
                for (int p = 0; p < int'(NPIN); p++) begin
                    if (sync2_q[p] == filt_q[p]) begin
                        stab_q[p] <= '0;
                    end else if (stab_q[p] == FCW'(FILTER_CYCLES - 1)) begin
                        filt_q[p] <= sync2_q[p];
                        stab_q[p] <= '0;
                    end else begin
                        stab_q[p] <= stab_q[p] + FCW'(1);
                    end
                end
            end
        end
        assign filt = filt_q;
    end

    assign win_term = (win_q == WW'(VEL_WINDOW - 1));
    assign settling = (settle_q != '0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            settle_q    <= SW'(FILTER_CYCLES + 3);
            win_q       <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            if (settling) settle_q <= settle_q - SW'(1);
            win_q       <= win_term ? '0 : win_q + WW'(1);
            vel_valid_q <= win_term;
        end
    end

    assign vel_valid = vel_valid_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]             cur;
        logic [1:0]             prev_q;
        logic [1:0]             pos_cur;
        logic [1:0]             pos_prev;
        logic [1:0]             diff;
        logic                   inc;
        logic                   dec;
        logic                   ill;
        logic                   clr_cnt;
        logic [COUNT_WIDTH-1:0] count_q;
        logic [COUNT_WIDTH-1:0] count_d;
        logic [VW1-1:0]         acc_sum;
        logic [VEL_WIDTH-1:0]   acc_sat;
        logic [VEL_WIDTH-1:0]   acc_q;
        logic [VEL_WIDTH-1:0]   acc_d;
        logic [VEL_WIDTH-1:0]   vel_q;
        logic [VEL_WIDTH-1:0]   vel_d;
        logic                   err_q;
        logic                   err_d;
`ifdef QUAD_ENC_INDEX_EN
        logic                   idx_prev_q;
        logic                   idx_rise;
        logic                   seen_q;
`endif

        // {A,B} read as Gray code {B,A}; its binary position difference gives the step.
        always_comb begin
            cur      = {filt[ch*PINS], filt[ch*PINS + 1]};
            pos_cur  = {cur[0], cur[1] ^ cur[0]};
            pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
            diff     = pos_cur - pos_prev;
            inc      = !settling && (diff == 2'd1);
            dec      = !settling && (diff == 2'd3);
            ill      = !settling && (diff == 2'd2);
`ifdef QUAD_ENC_INDEX_EN
            idx_rise = !settling && filt[ch*PINS + 2] && !idx_prev_q;
            clr_cnt  = zero[ch] | idx_rise;
`else
            clr_cnt  = zero[ch];
`endif
            count_d  = clr_cnt ? '0 : count_q + COUNT_WIDTH'(inc) - COUNT_WIDTH'(dec);
            acc_sum  = {acc_q[VEL_WIDTH-1], acc_q} + VW1'(inc) - VW1'(dec);
            if (acc_sum[VW1-1] != acc_sum[VW1-2]) begin
                acc_sat = acc_sum[VW1-1] ? VMIN : VMAX;
            end else begin
                acc_sat = acc_sum[VEL_WIDTH-1:0];
            end
            vel_d = vel_q;
            acc_d = acc_sat;
            if (win_term) begin
                vel_d = acc_sat;
                acc_d = '0;
            end
            err_d = ill | (err_q & ~error_clear[ch]);
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                prev_q  <= '0;
                count_q <= '0;
                acc_q   <= '0;
                vel_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                prev_q  <= cur;
                count_q <= count_d;
                acc_q   <= acc_d;
                vel_q   <= vel_d;
                err_q   <= err_d;
            end
        end

`ifdef QUAD_ENC_INDEX_EN
        always_ff @(posedge CLK) begin
            if (reset) begin
                idx_prev_q <= 1'b0;
                seen_q     <= 1'b0;
            end else begin
                idx_prev_q <= filt[ch*PINS + 2];
                seen_q     <= seen_q | idx_rise;
            end
        end
        assign index_seen[ch] = seen_q;
`endif

        assign count[ch*COUNT_WIDTH +: COUNT_WIDTH] = count_q;
        assign velocity[ch*VEL_WIDTH +: VEL_WIDTH]  = vel_q;
        assign error[ch]                            = err_q;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: two instances (filtered / unfiltered) driven by one stimulus stream,
// compared every cycle against a history-based reference model plus directed spot checks.
module tb_quad_encoder_array;

    localparam int W    = 100;
    localparam int MAXE = 16384;
    localparam int FD  [2] = '{4, 0};
    localparam int VMX [2] = '{7, 32767};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  qa, qb, zr, ec;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  vel_a;
    logic [31:0] vel_b;
    logic        vv_a, vv_b;
    logic [1:0]  err_a, err_b;

    always #5 clk = ~clk;

    quad_encoder_array #(.CHANNELS(2), .COUNT_WIDTH(8), .FILTER_CYCLES(4),
                         .VEL_WINDOW(W), .VEL_WIDTH(4)) u_f4 (
        .CLK(clk), .reset(rst), .quadA(qa), .quadB(qb), .zero(zr), .error_clear(ec),
        .count(cnt_a), .velocity(vel_a), .vel_valid(vv_a), .error(err_a));

    quad_encoder_array #(.CHANNELS(2), .COUNT_WIDTH(8), .FILTER_CYCLES(0),
                         .VEL_WINDOW(W), .VEL_WIDTH(16)) u_f0 (
        .CLK(clk), .reset(rst), .quadA(qa), .quadB(qb), .zero(zr), .error_clear(ec),
        .count(cnt_b), .velocity(vel_b), .vel_valid(vv_b), .error(err_b));

    // Reference model state, index [dut][channel]; dut 0 = u_f4, dut 1 = u_f0.
    bit         inA [2][MAXE];
    bit         inB [2][MAXE];
    bit         mfa [2][2];
    bit         mfb [2][2];
    logic [1:0] mprev [2][2];
    int         mcnt [2][2];
    int         macc [2][2];
    int         mvel [2][2];
    bit         merr [2][2];
    bit         mvv  [2];
    int         e;
    int         ntests = 0;
    int         nfail  = 0;

    function automatic int gpos(logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gab(int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int wrap8(int x);
        int y;
        y = (x + 128) % 256;
        if (y < 0) y += 256;
        return y - 128;
    endfunction

    function automatic int sat(int x, int mx);
        if (x > mx) return mx;
        if (x < -mx - 1) return -mx - 1;
        return x;
    endfunction

    // Raw pin level driven for edge idx; nothing is sampled before the first edge after reset.
    function automatic bit sbit(int c, int p, int idx);
        if (idx < 1) return 1'b0;
        return (p == 0) ? inA[c][idx] : inB[c][idx];
    endfunction

    // Filtered level after edge e: flips once the last F synced samples all disagree with it.
    function automatic bit filt_next(int d, int c, int p, bit cur);
        bit all;
        if (FD[d] == 0) return sbit(c, p, e - 1);
        all = 1'b1;
        for (int k = 0; k < FD[d]; k++) begin
            if (e - k < 1) all = 1'b0;
            else if (sbit(c, p, e - k - 2) == cur) all = 1'b0;
        end
        return all ? ~cur : cur;
    endfunction

    task automatic model_reset();
        e = 0;
        for (int d = 0; d < 2; d++) begin
            mvv[d] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                mfa[d][c] = 1'b0; mfb[d][c] = 1'b0; mprev[d][c] = 2'b00;
                mcnt[d][c] = 0; macc[d][c] = 0; mvel[d][c] = 0; merr[d][c] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        logic [1:0] fpre;
        int st, dl;
        bit ill;
        for (int d = 0; d < 2; d++) begin
            mvv[d] = (e % W == 0);
            for (int c = 0; c < 2; c++) begin
                fpre = {mfa[d][c], mfb[d][c]};
                st = 0;
                ill = 1'b0;
                if (e > FD[d] + 3 && fpre != mprev[d][c]) begin
                    dl = (gpos(fpre) - gpos(mprev[d][c]) + 4) % 4;
                    if (dl == 1) st = 1;
                    else if (dl == 3) st = -1;
                    else ill = 1'b1;
                end
                mcnt[d][c] = zr[c] ? 0 : wrap8(mcnt[d][c] + st);
                merr[d][c] = ill ? 1'b1 : (ec[c] ? 1'b0 : merr[d][c]);
                if (mvv[d]) begin
                    mvel[d][c] = sat(macc[d][c] + st, VMX[d]);
                    macc[d][c] = 0;
                end else begin
                    macc[d][c] = sat(macc[d][c] + st, VMX[d]);
                end
                mprev[d][c] = fpre;
                mfa[d][c] = filt_next(d, c, 0, mfa[d][c]);
                mfb[d][c] = filt_next(d, c, 1, mfb[d][c]);
            end
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s e=%0d observed=%0d expected=%0d", tag, e, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("f4_count%0d", c), $signed(cnt_a[c*8 +: 8]), mcnt[0][c]);
            chk($sformatf("f0_count%0d", c), $signed(cnt_b[c*8 +: 8]), mcnt[1][c]);
            chk($sformatf("f4_vel%0d", c), $signed(vel_a[c*4 +: 4]), mvel[0][c]);
            chk($sformatf("f0_vel%0d", c), $signed(vel_b[c*16 +: 16]), mvel[1][c]);
            chk($sformatf("f4_err%0d", c), int'(err_a[c]), int'(merr[0][c]));
            chk($sformatf("f0_err%0d", c), int'(err_b[c]), int'(merr[1][c]));
        end
        chk("f4_vel_valid", int'(vv_a), int'(mvv[0]));
        chk("f0_vel_valid", int'(vv_b), int'(mvv[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            e++;
            for (int c = 0; c < 2; c++) begin
                inA[c][e] = qa[c];
                inB[c][e] = qb[c];
            end
            model_edge();
        end
        #1;
        check_all();
    endtask

    task automatic hold(int n);
        repeat (n) cyc();
    endtask

    task automatic move(int c, int dir, int n);
        logic [1:0] ab;
        ab = gab(gpos({qa[c], qb[c]}) + dir + 4);
        qa[c] = ab[1];
        qb[c] = ab[0];
        hold(n);
    endtask

    task automatic random_phase(int moves);
        int c, n;
        for (int i = 0; i < moves; i++) begin
            c = int'($urandom % 2);
            if ($urandom % 16 == 0) begin
                qa[c] = ~qa[c];
                qb[c] = ~qb[c];
            end else begin
                move(c, ($urandom % 2 == 0) ? 1 : -1, 0);
            end
            n = int'($urandom_range(1, 10));
            repeat (n) begin
                zr = ($urandom % 32 == 0) ? 2'(1 << ($urandom % 2)) : 2'b00;
                ec = ($urandom % 32 == 0) ? 2'(1 << ($urandom % 2)) : 2'b00;
                cyc();
            end
            zr = 2'b00;
            ec = 2'b00;
        end
    endtask

    initial begin
        int nstrobe;
        rst = 1'b1; qa = 2'b11; qb = 2'b11; zr = 2'b00; ec = 2'b00;
        model_reset();
        hold(3);
        rst = 1'b0;
        hold(200);
        chk("idle_high_count0", $signed(cnt_a[7:0]), 0);
        chk("idle_high_err_f4", int'(err_a), 0);
        chk("idle_high_err_f0", int'(err_b), 0);

        repeat (32) move(0, 1, 20);
        chk("fwd32_f4", $signed(cnt_a[7:0]), 32);
        chk("fwd32_f0", $signed(cnt_b[7:0]), 32);
        chk("fwd32_ch1", $signed(cnt_a[15:8]), 0);
        repeat (40) move(0, -1, 20);
        chk("rev40_f4", $signed(cnt_a[7:0]), -8);
        chk("rev40_f0", $signed(cnt_b[7:0]), -8);

        qa[0] = 1'b0; hold(3); qa[0] = 1'b1; hold(20);
        chk("glitch_f4", $signed(cnt_a[7:0]), -8);
        qa[0] = 1'b0; hold(6);
        chk("latency_early", $signed(cnt_a[7:0]), -8);
        hold(1);
        chk("latency_edge", $signed(cnt_a[7:0]), -7);
        hold(10);

        qa[1] = 1'b0; qb[1] = 1'b0; hold(20);
        chk("illegal_err_f4", int'(err_a[1]), 1);
        chk("illegal_err_f0", int'(err_b[1]), 1);
        chk("illegal_cnt_f0", $signed(cnt_b[15:8]), 0);
        qa[1] = 1'b1; qb[1] = 1'b1; hold(2);
        ec[1] = 1'b1; hold(1); ec[1] = 1'b0;
        chk("set_beats_clear", int'(err_b[1]), 1);
        hold(20);
        ec[1] = 1'b1; hold(1); ec[1] = 1'b0;
        chk("clear_f4", int'(err_a[1]), 0);
        chk("clear_f0", int'(err_b[1]), 0);
        hold(5);

        zr[1] = 1'b1; hold(1); zr[1] = 1'b0;
        repeat (127) move(1, 1, 7);
        hold(10);
        chk("max_f4", $signed(cnt_a[15:8]), 127);
        chk("max_f0", $signed(cnt_b[15:8]), 127);
        move(1, 1, 10);
        chk("wrap_f4", $signed(cnt_a[15:8]), -128);
        chk("wrap_f0", $signed(cnt_b[15:8]), -128);
        move(1, 1, 2);
        zr[1] = 1'b1; hold(1); zr[1] = 1'b0;
        chk("zero_beats_step_f0", $signed(cnt_b[15:8]), 0);
        hold(10);
        chk("zero_then_step_f4", $signed(cnt_a[15:8]), 1);

        repeat (15) move(0, 1, 10);
        nstrobe = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) move(0, 1, 0);
            cyc();
            if (vv_b) begin
                nstrobe++;
                chk("vel10_f0", $signed(vel_b[15:0]), 10);
                chk("vel10_sat_f4", $signed(vel_a[3:0]), 7);
            end
        end
        chk("strobe_count", nstrobe, 3);
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) move(0, 1, 0);
            cyc();
            if (vv_a && i >= 150) chk("vel12_sat_f4", $signed(vel_a[3:0]), 7);
        end

        random_phase(250);
        rst = 1'b1; hold(2);
        chk("midreset_cnt0", $signed(cnt_a[7:0]), 0);
        chk("midreset_cnt1", $signed(cnt_b[15:8]), 0);
        rst = 1'b0;
        hold(30);
        random_phase(100);
        hold(20);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
